demux_1_to_n_stream: RTL

DEMUX_1_TO_N_STREAM -- requirements
Module: demux_1_to_n_stream

---
 rtl/demux_1_to_n_stream_if.sv | 23 ++
 rtl/demux_1_to_n_stream.sv | 44 ++++
 2 files changed

// File: rtl/demux_1_to_n_stream_if.sv
// demux_1_to_n_stream_if: upstream beat plus per-channel downstream streams for the 1-to-N demux.
interface demux_1_to_n_stream_if #(
   parameter int WIDTH = 32,
   parameter int N_OUT = 4
);
   localparam int SEL_W = ($clog2(N_OUT) > 1) ? $clog2(N_OUT) : 1;
   logic [WIDTH-1:0]       i_data;
   logic [SEL_W-1:0]       i_sel;
   logic                   i_valid;
   logic                   o_ready;
   logic [N_OUT*WIDTH-1:0] o_data;
   logic [N_OUT-1:0]       o_valid;
   logic [N_OUT-1:0]       i_ready;
   logic                   o_sel_err;
   modport slave (
      input  i_data, i_sel, i_valid, i_ready,
      output o_ready, o_data, o_valid, o_sel_err
   );
   modport master (
      output i_data, i_sel, i_valid, i_ready,
      input  o_ready, o_data, o_valid, o_sel_err
   );
endinterface

// File: rtl/demux_1_to_n_stream.sv
// demux_1_to_n_stream: routes one upstream stream to N independent one-entry output registers.
module demux_1_to_n_stream #(
   parameter int WIDTH = 32,
   parameter int N_OUT = 4
) (
   input logic                   i_clk,
   input logic                   i_rst,
   demux_1_to_n_stream_if.slave  s
);
   localparam int SEL_W = ($clog2(N_OUT) > 1) ? $clog2(N_OUT) : 1;
   logic [N_OUT*WIDTH-1:0] data_q, data_d;
   logic [N_OUT-1:0]       valid_q, valid_d, load;
   logic                   sel_err_q, sel_err_d;
   logic                   in_range, ready, accept;
   always_comb begin
      in_range = int'(s.i_sel) < N_OUT;
      // out-of-range beats are always taken so they can be dropped and flagged
      ready    = in_range ? (!valid_q[s.i_sel] || s.i_ready[s.i_sel]) : 1'b1;
      accept   = s.i_valid && ready;
      sel_err_d = accept && !in_range;
   end
   for (genvar k = 0; k < N_OUT; k++) begin : g_ch
      always_comb begin
         load[k] = accept && in_range && (s.i_sel == SEL_W'(k));
         valid_d[k] = load[k] || (valid_q[k] && !s.i_ready[k]);
         data_d[k*WIDTH +: WIDTH] = load[k] ? s.i_data : data_q[k*WIDTH +: WIDTH];
      end
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         data_q    <= '0;
         valid_q   <= '0;
         sel_err_q <= 1'b0;
      end else begin
         data_q    <= data_d;
         valid_q   <= valid_d;
         sel_err_q <= sel_err_d;
      end
   end
   assign s.o_ready   = ready;
   assign s.o_data    = data_q;
   assign s.o_valid   = valid_q;
   assign s.o_sel_err = sel_err_q;
endmodule
